// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared instruction-field widths and writeback source IDs
package wb_arbiter_pkg;

    localparam int LEN_REGNO = 5;
    localparam int LEN_REG   = 32;

    // Shared with the execute and memory stages so source tagging agrees everywhere.
    typedef enum logic {
        SRC_EXE = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_hold_buf.sv
// rtl/wb_hold_buf.sv - single-entry result holding buffer with valid/stall handshake
module wb_hold_buf
    import wb_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic [LEN_REGNO-1:0] regno_i,
    input  logic [LEN_REG-1:0]   data_i,
    input  logic                 drain_i,
    output logic                 stall_o,
    output logic                 capture_o,
    output logic                 full_o,
    output logic                 full_next_o,
    output logic [LEN_REGNO-1:0] regno_o,
    output logic [LEN_REG-1:0]   data_o
);

    logic                 full_q, full_d;
    logic [LEN_REGNO-1:0] regno_q, regno_d;
    logic [LEN_REG-1:0]   data_q, data_d;
    logic                 stall;
    logic                 capture;

    // A draining entry frees the slot in the same cycle, giving one result per cycle.
    always_comb begin
        stall   = full_q & ~drain_i;
        capture = valid_i & ~stall;
        full_d  = capture | (full_q & ~drain_i);
        regno_d = regno_q;
        data_d  = data_q;
        if (capture) begin
            regno_d = regno_i;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q  <= 1'b0;
            regno_q <= '0;
            data_q  <= '0;
        end else begin
            full_q  <= full_d;
            regno_q <= regno_d;
            data_q  <= data_d;
        end
    end

    assign stall_o     = stall;
    assign capture_o   = capture;
    assign full_o      = full_q;
    assign full_next_o = full_d;
    assign regno_o     = regno_q;
    assign data_o      = data_q;

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - age-ordered arbitration of exe and mem results onto the regfile write port
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 exe_valid_i,
    output logic                 exe_stall_o,
    input  logic [LEN_REGNO-1:0] exe_regno,
    input  logic [LEN_REG-1:0]   exe_data,
    input  logic                 mem_valid_i,
    output logic                 mem_stall_o,
    input  logic [LEN_REGNO-1:0] mem_regno,
    input  logic [LEN_REG-1:0]   mem_data,
    output logic                 wb_valid_o,
    input  logic                 wb_stall_i,
    output logic [LEN_REGNO-1:0] wb_regno,
    output logic [LEN_REG-1:0]   wb_data,
    output logic                 wb_src_o
);

    logic                 exe_full, exe_full_next, exe_cap, exe_drain;
    logic                 mem_full, mem_full_next, mem_cap, mem_drain;
    logic [LEN_REGNO-1:0] exe_buf_regno, mem_buf_regno;
    logic [LEN_REG-1:0]   exe_buf_data, mem_buf_data;
    logic                 grant_exe, grant_mem;
    wb_src_e              older_q, older_d;

    wb_hold_buf u_exe_buf (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (exe_valid_i),
        .regno_i     (exe_regno),
        .data_i      (exe_data),
        .drain_i     (exe_drain),
        .stall_o     (exe_stall_o),
        .capture_o   (exe_cap),
        .full_o      (exe_full),
        .full_next_o (exe_full_next),
        .regno_o     (exe_buf_regno),
        .data_o      (exe_buf_data)
    );

    wb_hold_buf u_mem_buf (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (mem_valid_i),
        .regno_i     (mem_regno),
        .data_i      (mem_data),
        .drain_i     (mem_drain),
        .stall_o     (mem_stall_o),
        .capture_o   (mem_cap),
        .full_o      (mem_full),
        .full_next_o (mem_full_next),
        .regno_o     (mem_buf_regno),
        .data_o      (mem_buf_data)
    );

    always_comb begin
        grant_mem  = mem_full & (~exe_full | (older_q == SRC_MEM));
        grant_exe  = exe_full & ~grant_mem;
        exe_drain  = grant_exe & ~wb_stall_i;
        mem_drain  = grant_mem & ~wb_stall_i;
        wb_valid_o = exe_full | mem_full;
        wb_src_o   = SRC_MEM;
        wb_regno   = '0;
        wb_data    = '0;
        if (grant_exe) begin
            wb_src_o = SRC_EXE;
            wb_regno = exe_buf_regno;
            wb_data  = exe_buf_data;
        end else if (grant_mem) begin
            wb_regno = mem_buf_regno;
            wb_data  = mem_buf_data;
        end
    end

    // Age follows the next-state occupancy; a simultaneous capture favours the load,
    // which was issued earlier in program order.
    always_comb begin
        older_d = older_q;
        if (exe_full_next && !mem_full_next) begin
            older_d = SRC_EXE;
        end else if (mem_full_next && !exe_full_next) begin
            older_d = SRC_MEM;
        end else if (exe_full_next && mem_full_next) begin
            if (exe_cap) begin
                older_d = SRC_MEM;
            end else if (mem_cap) begin
                older_d = SRC_EXE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            older_q <= SRC_MEM;
        end else begin
            older_q <= older_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 exe_valid_i, mem_valid_i, wb_stall_i;
    logic                 exe_stall_o, mem_stall_o, wb_valid_o, wb_src_o;
    logic [LEN_REGNO-1:0] exe_regno, mem_regno, wb_regno;
    logic [LEN_REG-1:0]   exe_data, mem_data, wb_data;

    typedef struct packed {
        logic                 src;
        logic [LEN_REGNO-1:0] regno;
        logic [LEN_REG-1:0]   data;
    } wr_t;

    wr_t sb[$];
    wr_t exp_wr;
    int  n_checks = 0;
    int  n_pass   = 0;

    wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .exe_valid_i (exe_valid_i),
        .exe_stall_o (exe_stall_o),
        .exe_regno   (exe_regno),
        .exe_data    (exe_data),
        .mem_valid_i (mem_valid_i),
        .mem_stall_o (mem_stall_o),
        .mem_regno   (mem_regno),
        .mem_data    (mem_data),
        .wb_valid_o  (wb_valid_o),
        .wb_stall_i  (wb_stall_i),
        .wb_regno    (wb_regno),
        .wb_data     (wb_data),
        .wb_src_o    (wb_src_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic src, input logic [LEN_REGNO-1:0] regno, input logic [LEN_REG-1:0] data);
        wr_t w;
        w.src   = src;
        w.regno = regno;
        w.data  = data;
        sb.push_back(w);
    endtask

    // Every write the port actually performs must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && wb_valid_o && !wb_stall_i) begin
            if (sb.size() == 0) begin
                check("wb_unexpected_write", {wb_src_o, wb_regno, wb_data}, 0);
            end else begin
                exp_wr = sb.pop_front();
                check("wb_src", wb_src_o, exp_wr.src);
                check("wb_regno", wb_regno, exp_wr.regno);
                check("wb_data", wb_data, exp_wr.data);
            end
        end
    end

    initial begin
        rst = 1'b1;
        exe_valid_i = 0; exe_regno = '0; exe_data = '0;
        mem_valid_i = 0; mem_regno = '0; mem_data = '0;
        wb_stall_i = 0;
        #2;
        check("rst_wb_valid", wb_valid_o, 0);
        check("rst_exe_stall", exe_stall_o, 0);
        check("rst_mem_stall", mem_stall_o, 0);
        check("rst_wb_src", wb_src_o, 1);
        check("rst_wb_regno", wb_regno, 0);
        check("rst_wb_data", wb_data, 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // single exe result
        exe_valid_i = 1; exe_regno = 3; exe_data = 32'h12;
        push(0, 3, 32'h12);
        tick();
        exe_valid_i = 0;
        @(negedge clk);
        check("s1_wb_valid", wb_valid_o, 1);
        check("s1_wb_src", wb_src_o, 0);
        tick();
        @(negedge clk);
        check("s1_wb_idle", wb_valid_o, 0);
        tick();
        check("s1_sb_empty", sb.size(), 0);

        // simultaneous capture: mem wins, exe stalls exactly one cycle
        exe_valid_i = 1; exe_regno = 5; exe_data = 32'hA;
        mem_valid_i = 1; mem_regno = 6; mem_data = 32'hB;
        push(1, 6, 32'hB);
        push(0, 5, 32'hA);
        tick();
        mem_valid_i = 0;
        exe_regno = 8; exe_data = 32'hC;
        push(0, 8, 32'hC);
        @(negedge clk);
        check("s2_exe_stall_hi", exe_stall_o, 1);
        check("s2_mem_stall", mem_stall_o, 0);
        tick();
        @(negedge clk);
        check("s2_exe_stall_lo", exe_stall_o, 0);
        tick();
        exe_valid_i = 0;
        repeat (3) tick();
        check("s2_sb_empty", sb.size(), 0);

        // same regno, mem first, exe second, under backpressure
        wb_stall_i = 1;
        mem_valid_i = 1; mem_regno = 7; mem_data = 32'h1;
        push(1, 7, 32'h1);
        tick();
        mem_valid_i = 0;
        exe_valid_i = 1; exe_regno = 7; exe_data = 32'h2;
        push(0, 7, 32'h2);
        tick();
        exe_valid_i = 0;
        @(negedge clk);
        check("s3_exe_stall", exe_stall_o, 1);
        check("s3_mem_stall", mem_stall_o, 1);
        check("s3_hold_src", wb_src_o, 1);
        tick();
        wb_stall_i = 0;
        repeat (3) tick();
        check("s3_sb_empty", sb.size(), 0);

        // back-to-back exe stream
        for (int i = 0; i < 4; i++) begin
            exe_valid_i = 1; exe_regno = 5'(9 + i); exe_data = 32'(32'h10 + i);
            push(0, 5'(9 + i), 32'(32'h10 + i));
            @(negedge clk);
            check("s4_exe_stall", exe_stall_o, 0);
            if (i > 0) check("s4_wb_valid", wb_valid_o, 1);
            tick();
        end
        exe_valid_i = 0;
        @(negedge clk);
        check("s4_last_valid", wb_valid_o, 1);
        repeat (3) tick();
        check("s4_sb_empty", sb.size(), 0);

        // write-port backpressure with exe older
        wb_stall_i = 1;
        exe_valid_i = 1; exe_regno = 1; exe_data = 32'hAA;
        push(0, 1, 32'hAA);
        tick();
        exe_valid_i = 0;
        mem_valid_i = 1; mem_regno = 2; mem_data = 32'hBB;
        push(1, 2, 32'hBB);
        tick();
        mem_valid_i = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s5_exe_stall", exe_stall_o, 1);
            check("s5_mem_stall", mem_stall_o, 1);
            check("s5_wb_valid", wb_valid_o, 1);
            check("s5_wb_src", wb_src_o, 0);
            check("s5_wb_regno", wb_regno, 1);
            check("s5_wb_data", wb_data, 32'hAA);
            tick();
        end
        wb_stall_i = 0;
        repeat (3) tick();
        check("s5_sb_empty", sb.size(), 0);

        // asynchronous reset with both buffers full; entries are discarded
        wb_stall_i = 1;
        exe_valid_i = 1; exe_regno = 10; exe_data = 32'h55;
        mem_valid_i = 1; mem_regno = 11; mem_data = 32'h66;
        tick();
        exe_valid_i = 0; mem_valid_i = 0;
        #1;
        check("s6_pre_valid", wb_valid_o, 1);
        #2;
        rst = 1'b1;
        #1;
        check("s6_rst_valid", wb_valid_o, 0);
        check("s6_rst_src", wb_src_o, 1);
        check("s6_rst_regno", wb_regno, 0);
        check("s6_rst_data", wb_data, 0);
        check("s6_rst_exe_stall", exe_stall_o, 0);
        check("s6_rst_mem_stall", mem_stall_o, 0);
        tick();
        rst = 1'b0;
        wb_stall_i = 0;
        @(negedge clk);
        check("s6_post_valid", wb_valid_o, 0);
        repeat (4) tick();
        check("s6_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single register-file write port between two result producers: the execute path (ALU results) and the memory path (load data returning late).
- Each source gets a one-entry holding buffer with a valid/stall handshake.
- Each cycle the arbiter grants the oldest buffered result to the write port, so writes to the same register are applied in capture order.
- Sits between the execute/memory stages and the register file, in place of a direct writeback-to-regfile connection.

Parameters:
- LEN_REGNO, from defs_insn.v: register-number width.
- LEN_REG, from defs_insn.v: register data width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- exe_valid_i  input  1  execute result present this cycle.
- exe_stall_o  output  1  execute result not accepted; source must hold its inputs.
- exe_regno  input  LEN_REGNO  destination register of the execute result.
- exe_data  input  LEN_REG  execute result data.
- mem_valid_i  input  1  load data present this cycle.
- mem_stall_o  output  1  load data not accepted; source must hold its inputs.
- mem_regno  input  LEN_REGNO  destination register of the load.
- mem_data  input  LEN_REG  load data.
- wb_valid_o  output  1  write-port request this cycle.
- wb_stall_i  input  1  register file cannot accept a write this cycle.
- wb_regno  output  LEN_REGNO  register to write.
- wb_data  output  LEN_REG  data to write.
- wb_src_o  output  1  granted source: 0 = exe, 1 = mem (debug/verification visibility).

Behaviour:
- State:
  - full_exe, full_mem: buffer occupied flags.
  - buf_*_regno, buf_*_data: buffered destination and data.
  - older: which full buffer was captured first; 0 = exe, 1 = mem.
- Reset while rst high, asynchronous:
  - full_exe = full_mem = 0; older = 1; buffered data cleared.
  - Outputs during reset: wb_valid_o = 0, exe_stall_o = 0, mem_stall_o = 0, wb_src_o = 1, wb_regno = 0, wb_data = 0.
  - Reset mid-operation discards any buffered results. No write is issued for them.
- Grant (combinational from state):
  - Only full_exe: grant exe.
  - Only full_mem: grant mem.
  - Both full: grant the buffer named by `older`.
  - Neither full: no grant; wb_valid_o = 0, wb_src_o = 1, wb_regno/wb_data = 0.
- Write port:
  - wb_valid_o = full_exe | full_mem.
  - wb_regno, wb_data, wb_src_o come from the granted buffer.
- Drain: drain_x = grant_x & ~wb_stall_i. At posedge, a drained buffer clears unless it captures a new entry in the same cycle.
- Accept / stall:
  - stall_o_x = full_x & ~drain_x.
  - Capture at posedge when valid_i_x & ~stall_o_x; regno and data are latched.
  - Capture in the same cycle as drain is allowed: back-to-back throughput of 1 per source while that source is granted.
  - While stalled, the source holds valid, regno and data stable. The arbiter ignores the held values until accept.
- Latency: a result accepted at edge N appears on wb_* in cycle N+1 if it wins arbitration. The write port is combinational from the buffers; there is no extra output register.
- Age update at posedge, evaluated on next-state full flags:
  - Only one buffer full next: older points to it.
  - Both full, one newly captured (the other retained): older points to the retained one.
  - Both newly captured in the same cycle: older = 1 (mem), since the load was issued earlier in program order.
- Both sources targeting the same regno: both writes are performed in age order. The later write overwrites. No merge or suppression.
- wb_stall_i held high:
  - Both buffers fill and both stall_o rise.
  - No state changes, and wb_* stays constant on the granted buffer.
- The arbiter never writes without a captured entry and never drops an accepted entry except on reset.

Decomposition:
- LEN_REGNO and LEN_REG come from defs_insn.v.
- Source IDs SRC_EXE = 0 and SRC_MEM = 1 are added to defs_insn.v; the execute and memory stages share them.
- One natural sub-module, wb_hold_buf: a single-entry buffer with valid/stall handshake, instantiated once per source. Arbitration and age logic stay in wb_arbiter.

Test Plan:
- Single exe: exe_valid_i = 1, regno = 3, data = 0x12 for one cycle, wb_stall_i = 0 -> the next cycle shows wb_valid_o = 1, wb_regno = 3, wb_data = 0x12, wb_src_o = 0; the following cycle wb_valid_o = 0.
- Simultaneous capture: exe (r5, 0xA) and mem (r6, 0xB) accepted in the same cycle -> the next cycle writes r6/0xB (src 1), then r5/0xA (src 0). exe_stall_o = 1 for exactly one cycle if exe presents a new result.
- Same-regno ordering: mem (r7, 0x1) accepted at edge N, then exe (r7, 0x2) at edge N+1 with wb_stall_i = 1 for 2 cycles -> after release, the write order is 0x1 then 0x2.
- Back-to-back exe: exe streams 4 results (0x10..0x13) on consecutive cycles with mem idle -> 4 consecutive writes and exe_stall_o never asserted.
- Write-port backpressure: both buffers full with wb_stall_i = 1 for 5 cycles -> both stall_o = 1 and wb_* constant for 5 cycles; then two writes in age order.
- Reset mid-operation: both buffers full, assert rst asynchronously between edges -> wb_valid_o = 0 immediately. After rst release, no write occurs for the discarded entries.
